page_ram_arbiter: RTL and testbench
===================================

// Module: page_ram_arbiter
// PURPOSE
//  Arbitrates the single-port page RAM (8 KB page data + status bytes) among three requesters:
//  P0 = flash datapath (read/write stream), P1 = ECC bit-correction / status writer, P2 = host readout.
//  Sits between the flash controllers/host interface and the RAM; owns ram_en/ram_we/ram_addr/ram_din.
//  Routes read data back with a per-port valid strobe.
// PARAMETERS
//  AW         15    address width
//  DW         8     data width
//  RAM_DEPTH  8194  valid addresses 0..RAM_DEPTH-1 (8192 data + 8192/8193 status)
//  MAX_BURST  16    max consecutive granted cycles for P1/P2 when others wait; 0 = unlimited
//  RAM_LAT    1     RAM read latency in cycles (1..4)
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous, active-high reset
//  req        in   3      request per port; held high for the whole burst
//  gnt        out  3      one-hot grant (registered), at most one bit set
//  en         in   3      per-port access strobe; effective only while gnt[i]
//  we         in   3      per-port write enable (1 = write, 0 = read)
//  addr       in   3*AW   per-port address, port i at [i*AW +: AW]
//  din        in   3*DW   per-port write data, port i at [i*DW +: DW]
//  rdata      out  DW     RAM read data (ram_dout passthrough, shared)
//  rvalid     out  3      rdata valid for port i, RAM_LAT cycles after its read access
//  access_err out  1      1-cycle pulse: granted access with addr >= RAM_DEPTH (access dropped)
//  ram_en     out  1      RAM enable
//  ram_we     out  1      RAM write enable
//  ram_addr   out  AW     RAM address
//  ram_din    out  DW     RAM write data
//  ram_dout   in   DW     RAM read data
// BEHAVIOUR
//  - Reset: gnt=0, rvalid=0, access_err=0, ram_en=ram_we=0, ram_addr=ram_din=0; FSM=IDLE;
//    burst counter=0; RR pointer prefers P1; rvalid pipeline cleared. Reset mid-burst aborts silently.
//  - FSM IDLE: if any req, pick winner and go GRANT; gnt[winner] rises next edge (req->gnt = 1 cycle).
//    Priority: P0 strictly first; else P1/P2 round-robin (port not granted last wins if both request).
//  - FSM GRANT: RAM mux driven combinationally from granted port: ram_en = en[g] & in_range,
//    ram_we = we[g] & ram_en, ram_addr/ram_din = port g fields; zeros when not granted.
//  - Release: req[g]=0 -> gnt=0 next edge, back to IDLE; one dead cycle before the next grant.
//  - Forced release (P1/P2 only, MAX_BURST!=0): burst counter counts GRANT cycles from 0; when it
//    reaches MAX_BURST-1 and any other req is high, gnt drops next edge; requester keeps req and
//    re-arbitrates normally. P0 is never forced off. Counter clears on every grant.
//  - en high while gnt low: ignored, no RAM access, no error.
//  - in_range = addr < RAM_DEPTH; out-of-range granted en -> ram_en=0, access_err=1 one cycle later
//    (registered), no rvalid.
//  - rvalid[i]: RAM_LAT-stage shift of (gnt[i] & en[i] & ~we[i] & in_range); writes produce none.
//    Reads in flight complete (rvalid still fires) after gnt drops.
//  - RR pointer updates only when P1 or P2 is granted; P0 grants leave it unchanged.
// TESTING
//  1) P0 req, en=1,we=1 for 8192 cycles, addr 0..8191 -> gnt[0] 1 cycle after req, 8192 RAM writes, no gap.
//  2) P1,P2 req together at same cycle, P1 granted last -> gnt[2] first; after P2 drops, 1 dead cycle, gnt[1].
//  3) P2 bursting, P1 req at cycle 3, MAX_BURST=16 -> gnt[2] drops after 16th cycle, gnt[1] 2 cycles later.
//  4) P1 read addr 8192, RAM_LAT=1 -> rvalid[1] one cycle after access, rdata = stored 0x55.
//  5) P2 read addr 9000 -> ram_en stays 0, access_err pulses once, rvalid[2] never set.
//  6) rst asserted mid-P1 write burst -> all outputs 0 same cycle; after release, P0 req granted normally.

Source files
------------

// File: rtl/page_ram_arbiter.sv
// Three-port arbiter for the single-port page RAM: P0 (flash datapath) has strict priority,
// P1 (ECC/status) and P2 (host readout) share round-robin with a burst limit.
module page_ram_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 8,
  parameter int RAM_DEPTH = 8194,
  parameter int MAX_BURST = 16,
  parameter int RAM_LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req,
  output logic [2:0]      gnt,
  input  logic [2:0]      en,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] din,
  output logic [DW-1:0]   rdata,
  output logic [2:0]      rvalid,
  output logic            access_err,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout,
  output logic            dbg_state
);

  // Handshake: a port raises req[i] and holds it for its whole burst; gnt[i] rises one edge
  // later. While gnt[i] is high, en[i]/we[i]/addr/din of port i drive the RAM in the same
  // cycle. Dropping req[i] releases the grant on the next edge; the RAM then idles one cycle.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int            BW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LP_BMAX = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(RAM_DEPTH);

  state_t        r_state, w_state_nx;
  logic [2:0]    r_gnt, w_gnt_nx;
  logic [BW-1:0] r_burst, w_burst_nx;
  logic          r_pref_p1, w_pref_nx;
  logic          r_err;
  logic [2:0]    r_rv_pipe [RAM_LAT];

  logic [2:0]    w_win;
  logic          w_force;
  logic          w_sel_en, w_sel_we, w_in_range;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_din;
  logic [2:0]    w_rd_hit;

  // Winner selection: P0 strictly first, then P1/P2 by round-robin preference.
  always_comb begin
    w_win = 3'b000;
    if (req[0])               w_win = 3'b001;
    else if (req[1] & req[2]) w_win = r_pref_p1 ? 3'b010 : 3'b100;
    else if (req[1])          w_win = 3'b010;
    else if (req[2])          w_win = 3'b100;
  end

  assign w_force = (MAX_BURST != 0) && !r_gnt[0] && (r_burst == LP_BMAX) && |(req & ~r_gnt);

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_burst_nx = r_burst;
    w_pref_nx  = r_pref_p1;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nx = GRANT;
          w_gnt_nx   = w_win;
          w_burst_nx = '0;
          if (w_win[1]) w_pref_nx = 1'b0;
          if (w_win[2]) w_pref_nx = 1'b1;
        end
      end
      GRANT: begin
        if (!(|(req & r_gnt)) || w_force) begin
          w_state_nx = IDLE;
          w_gnt_nx   = 3'b000;
          w_burst_nx = '0;
        end else if (r_burst != LP_BMAX) begin
          // Saturates so a late-arriving competitor still forces the release.
          w_burst_nx = r_burst + 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_gnt_nx   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= 3'b000;
      r_burst   <= '0;
      r_pref_p1 <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_burst   <= w_burst_nx;
      r_pref_p1 <= w_pref_nx;
    end
  end

  always_comb begin
    w_sel_en   = 1'b0;
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    for (int i = 0; i < 3; i++) begin
      if (r_gnt[i]) begin
        w_sel_en   = en[i];
        w_sel_we   = we[i];
        w_sel_addr = addr[i*AW +: AW];
        w_sel_din  = din[i*DW +: DW];
      end
    end
  end

  assign w_in_range = ({1'b0, w_sel_addr} < LP_DEPTH);
  assign ram_en     = w_sel_en & w_in_range;
  assign ram_we     = w_sel_we & ram_en;
  assign ram_addr   = w_sel_addr;
  assign ram_din    = w_sel_din;
  assign w_rd_hit   = r_gnt & en & ~we & {3{w_in_range}};

  // Read strobes travel with the RAM latency, so they complete even after the grant drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
      for (int k = 0; k < RAM_LAT; k++) r_rv_pipe[k] <= 3'b000;
    end else begin
      r_err        <= |r_gnt & w_sel_en & ~w_in_range;
      r_rv_pipe[0] <= w_rd_hit;
      for (int k = 1; k < RAM_LAT; k++) r_rv_pipe[k] <= r_rv_pipe[k-1];
    end
  end

  assign gnt        = r_gnt;
  assign rvalid     = r_rv_pipe[RAM_LAT-1];
  assign access_err = r_err;
  assign rdata      = ram_dout;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_page_ram_arbiter.sv
// Bench for page_ram_arbiter: per-cycle vector table plus directed multi-cycle sequences
// (P0 stream, round-robin, forced release, status-byte read, reset mid-burst).
module tb_page_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      req = '0, en = '0, we = '0;
  logic [AW-1:0]   a0 = '0, a1 = '0, a2 = '0;
  logic [DW-1:0]   d0 = '0, d1 = '0, d2 = '0;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] din;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, ram_din, ram_dout;
  logic            access_err, ram_en, ram_we, dbg_state;
  logic [AW-1:0]   ram_addr;

  logic [DW-1:0]   mem [0:8193];
  logic [AW+DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  assign addr = {a2, a1, a0};
  assign din  = {d2, d1, d0};

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  page_ram_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .en(en), .we(we), .addr(addr), .din(din),
    .rdata(rdata), .rvalid(rvalid), .access_err(access_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  typedef struct {
    logic [2:0]    req, en, we;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    x_gnt;
    logic          x_en, x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_din;
    logic          x_err;
    logic [2:0]    x_rv;
    logic          chk_rd;
    logic [DW-1:0] x_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] r, input logic [2:0] e, input logic [2:0] w,
                     input int aa0, input int aa1, input int aa2,
                     input logic [7:0] dd0, input logic [7:0] dd1, input logic [7:0] dd2,
                     input logic [2:0] xg, input logic xe, input logic xw, input int xa,
                     input logic [7:0] xd, input logic xerr, input logic [2:0] xrv,
                     input logic crd, input logic [7:0] xrd);
    vec_t v;
    v.req = r; v.en = e; v.we = w;
    v.a0 = AW'(aa0); v.a1 = AW'(aa1); v.a2 = AW'(aa2);
    v.d0 = dd0; v.d1 = dd1; v.d2 = dd2;
    v.x_gnt = xg; v.x_en = xe; v.x_we = xw; v.x_addr = AW'(xa); v.x_din = xd;
    v.x_err = xerr; v.x_rv = xrv; v.chk_rd = crd; v.x_rd = xrd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; en = '0; we = '0;
    a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
  endtask

  initial begin
    logic [AW-1:0] ka;
    logic [DW-1:0] kd;
    int n;

    // req en we | a0 a1 a2 | d0 d1 d2 || gnt ren rwe raddr rdin err rv | chk rdata
    add(0, 0, 0,  0,    0,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(1, 1, 1, 10,    0,    0,  8'hAA, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(1, 1, 1, 10,    0,    0,  8'hAA, 8'h00, 8'h00,  1, 1, 1,   10, 8'hAA, 0, 0,  0, 8'h00);
    add(1, 1, 0, 10,    0,    0,  8'hAA, 8'h00, 8'h00,  1, 1, 0,   10, 8'hAA, 0, 0,  0, 8'h00);
    add(0, 0, 0, 10,    0,    0,  8'hAA, 8'h00, 8'h00,  1, 0, 0,   10, 8'hAA, 0, 1,  1, 8'hAA);
    add(0, 0, 0,  0,    0,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(2, 2, 2,  0, 8193,    0,  8'h00, 8'h55, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(2, 2, 2,  0, 8193,    0,  8'h00, 8'h55, 8'h00,  2, 1, 1, 8193, 8'h55, 0, 0,  0, 8'h00);
    add(6, 0, 0,  0, 8193,    0,  8'h00, 8'h55, 8'h00,  2, 0, 0, 8193, 8'h55, 0, 0,  0, 8'h00);
    add(4, 4, 0,  0, 8193, 8193,  8'h00, 8'h55, 8'h33,  2, 0, 0, 8193, 8'h55, 0, 0,  0, 8'h00);
    add(4, 4, 0,  0, 8193, 8193,  8'h00, 8'h55, 8'h33,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(4, 4, 0,  0, 8193, 8193,  8'h00, 8'h55, 8'h33,  4, 1, 0, 8193, 8'h33, 0, 0,  0, 8'h00);
    add(0, 0, 0,  0, 8193, 8193,  8'h00, 8'h55, 8'h33,  4, 0, 0, 8193, 8'h33, 0, 4,  1, 8'h55);
    add(0, 0, 0,  0,    0,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(4, 4, 0,  0,    0, 9000,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(4, 4, 0,  0,    0, 9000,  8'h00, 8'h00, 8'h00,  4, 0, 0, 9000, 8'h00, 0, 0,  0, 8'h00);
    add(4, 0, 0,  0,    0, 9000,  8'h00, 8'h00, 8'h00,  4, 0, 0, 9000, 8'h00, 1, 0,  0, 8'h00);
    add(0, 0, 0,  0,    0, 9000,  8'h00, 8'h00, 8'h00,  4, 0, 0, 9000, 8'h00, 0, 0,  0, 8'h00);
    add(0, 0, 0,  0,    0,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(7, 0, 0,  5,    7,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(7, 0, 0,  5,    7,    0,  8'h00, 8'h00, 8'h00,  1, 0, 0,    5, 8'h00, 0, 0,  0, 8'h00);
    add(6, 0, 0,  5,    7,    0,  8'h00, 8'h00, 8'h00,  1, 0, 0,    5, 8'h00, 0, 0,  0, 8'h00);
    add(6, 0, 0,  5,    7,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);
    add(6, 0, 0,  5,    7,    0,  8'h00, 8'h00, 8'h00,  2, 0, 0,    7, 8'h00, 0, 0,  0, 8'h00);
    add(0, 0, 0,  5,    7,    0,  8'h00, 8'h00, 8'h00,  2, 0, 0,    7, 8'h00, 0, 0,  0, 8'h00);
    add(0, 0, 0,  0,    0,    0,  8'h00, 8'h00, 8'h00,  0, 0, 0,    0, 8'h00, 0, 0,  0, 8'h00);

    // Clock/reset
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {gnt, ram_en, ram_we, ram_addr, ram_din, access_err, rvalid, dbg_state}, '0);
    rst = 1'b0;

    // Vector table: one row per clock cycle
    foreach (vecs[i]) begin
      req = vecs[i].req; en = vecs[i].en; we = vecs[i].we;
      a0 = vecs[i].a0; a1 = vecs[i].a1; a2 = vecs[i].a2;
      d0 = vecs[i].d0; d1 = vecs[i].d1; d2 = vecs[i].d2;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {gnt, ram_en, ram_we, ram_addr, ram_din, access_err, rvalid},
            {vecs[i].x_gnt, vecs[i].x_en, vecs[i].x_we, vecs[i].x_addr, vecs[i].x_din,
             vecs[i].x_err, vecs[i].x_rv});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].x_rd);
      step();
    end

    // P1 granted last: simultaneous P1/P2 request goes to P2, then one dead cycle before P1
    req = 3'b110;
    @(negedge clk); check("rr_wait", gnt, 3'b000);
    step(); @(negedge clk); check("rr_p2_first", gnt, 3'b100);
    check("dbg_grant", dbg_state, 1'b1);
    step(); step();
    req = 3'b010;
    @(negedge clk); check("rr_p2_hold", gnt, 3'b100);
    step(); @(negedge clk); check("rr_dead_cycle", gnt, 3'b000);
    step(); @(negedge clk); check("rr_p1_next", gnt, 3'b010);
    req = 3'b000;
    step(); step(); step();

    // P2 burst with P1 arriving at grant cycle 3: forced off after 16 cycles
    req = 3'b100;
    step();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt != 3'b100) break;
      n++;
      if (n == 3) req[1] = 1'b1;
      step();
    end
    check("burst_len", 64'(n), 64'd16);
    check("burst_dead_cycle", gnt, 3'b000);
    step(); @(negedge clk); check("burst_p1_next", gnt, 3'b010);
    req = 3'b000;
    step(); step(); step();

    // P0 streams 8192 back-to-back writes, grant one cycle after request
    req = 3'b001; en = 3'b001; we = 3'b001; a0 = '0; d0 = '0;
    @(negedge clk); check("p0_not_yet", {gnt, ram_en}, 4'b0000);
    step();
    for (int k = 0; k < 8192; k++) begin
      ka = AW'(k);
      kd = ka[7:0] ^ {1'b0, ka[14:8]};
      a0 = ka; d0 = kd;
      exp_q.push_back({ka, kd});
      @(negedge clk);
      if (k == 0) check("p0_gnt_latency", gnt, 3'b001);
      check("p0_stream", {ram_en, ram_we, ram_addr, ram_din}, {2'b11, exp_q.pop_front()});
      step();
    end
    idle_inputs();
    check("p0_queue_empty", 64'(exp_q.size()), 64'd0);
    step(); step();

    // P1 writes status byte 8192 = 0x55, reads it back one cycle later
    req = 3'b010; en = 3'b010; we = 3'b010; a1 = AW'(8192); d1 = 8'h55;
    @(negedge clk); check("st_wait", gnt, 3'b000);
    step(); @(negedge clk); check("st_write", {gnt, ram_en, ram_we}, {3'b010, 2'b11});
    step(); we = 3'b000;
    @(negedge clk); check("st_read", {ram_en, ram_we, rvalid}, {2'b10, 3'b000});
    step(); en = 3'b000;
    @(negedge clk); check("st_rvalid", rvalid, 3'b010);
    check("st_rdata", rdata, 8'h55);
    step(); @(negedge clk); check("st_rvalid_clear", rvalid, 3'b000);
    idle_inputs();
    step(); step();

    // Reset in the middle of a P1 write burst, then P0 granted normally
    req = 3'b010; en = 3'b010; we = 3'b010; a1 = AW'(100); d1 = 8'h77;
    step(); step();
    @(negedge clk); check("pre_rst_burst", {gnt, ram_en, ram_we}, {3'b010, 2'b11});
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_burst", {gnt, ram_en, ram_we, ram_addr, ram_din, access_err, rvalid, dbg_state}, '0);
    idle_inputs();
    step();
    rst = 1'b0;
    req = 3'b001;
    @(negedge clk); check("post_rst_idle", gnt, 3'b000);
    step(); @(negedge clk); check("post_rst_p0", gnt, 3'b001);
    idle_inputs();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
